// File: rtl/bios_loader.sv
// rtl/bios_loader.sv - copies BIOS ROM words into instruction memory up to and including the hlt word.
// Each issued address is tracked through a two-stage valid/address tag matching the ROM's read register.
module bios_loader #(
    parameter int unsigned     BIOS_DEPTH = 64,
    parameter int unsigned     DATA_W     = 32,
    parameter int unsigned     ADDR_W     = 32,
    parameter int unsigned     IMEM_BASE  = 0,
    parameter logic [5:0]      HLT_OPCODE = 6'b011101
) (
    input  logic                        clk_auto,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [ADDR_W-1:0]           biosAddr,
    input  logic [DATA_W-1:0]           biosIn,
    output logic                        imemWe,
    output logic [ADDR_W-1:0]           imemAddr,
    output logic [DATA_W-1:0]           imemData,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [$clog2(BIOS_DEPTH):0] wordCount
);
    localparam int unsigned CW = $clog2(BIOS_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BIOS_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   bios_addr_q, bios_addr_d;
    logic                v1_q, v1_d, v2_q, v2_d;
    logic [ADDR_W-1:0]   a1_q, a1_d, a2_q, a2_d;
    logic                we_q, we_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                hlt_now, end_miss;

    // Termination is judged on the word currently on the write port.
    assign hlt_now  = we_q && (wdata_q[DATA_W-1 -: 6] == HLT_OPCODE);
    assign end_miss = we_q && last_q && !hlt_now;

    always_ff @(posedge clk_auto or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bios_addr_q <= '0;
            v1_q        <= 1'b0;
            a1_q        <= '0;
            v2_q        <= 1'b0;
            a2_q        <= '0;
            we_q        <= 1'b0;
            last_q      <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bios_addr_q <= bios_addr_d;
            v1_q        <= v1_d;
            a1_q        <= a1_d;
            v2_q        <= v2_d;
            a2_q        <= a2_d;
            we_q        <= we_d;
            last_q      <= last_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bios_addr_d = bios_addr_q;
        v1_d        = v1_q;
        a1_d        = a1_q;
        v2_d        = v2_q;
        a2_d        = a2_q;
        we_d        = 1'b0;
        last_d      = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    bios_addr_d = '0;
                    v1_d        = 1'b1;
                    a1_d        = '0;
                    v2_d        = 1'b0;
                    a2_d        = '0;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                end
            end
            default: begin
                if (hlt_now || end_miss) begin
                    // Younger in-flight words are squashed by clearing both tags.
                    state_d = S_DONE;
                    v1_d    = 1'b0;
                    v2_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = end_miss;
                end else begin
                    we_d = v2_q;
                    if (v2_q) begin
                        waddr_d = ADDR_W'(IMEM_BASE) + a2_q;
                        wdata_d = biosIn;
                        last_d  = (a2_q == LAST_ADDR);
                        if (cnt_q != CW'(BIOS_DEPTH))
                            cnt_d = cnt_q + CW'(1);
                    end
                    v2_d = v1_q;
                    a2_d = a1_q;
                    if (state_q == S_LOAD && bios_addr_q != LAST_ADDR) begin
                        bios_addr_d = bios_addr_q + ADDR_W'(1);
                        v1_d        = 1'b1;
                        a1_d        = bios_addr_q + ADDR_W'(1);
                    end else begin
                        state_d = S_DRAIN;
                        v1_d    = 1'b0;
                    end
                end
            end
        endcase
    end

    assign biosAddr  = bios_addr_q;
    assign imemWe    = we_q;
    assign imemAddr  = waddr_q;
    assign imemData  = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = err_q;
    assign wordCount = cnt_q;
endmodule

// File: tb/tb_bios_loader.sv
// tb/tb_bios_loader.sv - scoreboard bench for bios_loader with a behavioural ROM and copy model.
module tb_bios_loader;
    localparam logic [5:0] HLT = 6'b011101;

    logic        clk_auto = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [31:0] biosAddr;
    logic [31:0] biosIn   = '0;
    logic        imemWe;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic        busy, done, error;
    logic [6:0]  wordCount;

    bios_loader dut (
        .clk_auto (clk_auto),
        .rst_n    (rst_n),
        .start    (start),
        .biosAddr (biosAddr),
        .biosIn   (biosIn),
        .imemWe   (imemWe),
        .imemAddr (imemAddr),
        .imemData (imemData),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .wordCount(wordCount)
    );

    always #5 clk_auto = ~clk_auto;

    logic [31:0] rom [64];
    always @(posedge clk_auto) biosIn <= rom[biosAddr[5:0]];

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int rises = 0;
    bit prev_we = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every observed write must match the head of the expected queue.
    always @(negedge clk_auto) begin
        if (rst_n && imemWe) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", {32'b0, imemAddr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("imem_addr", {32'b0, imemAddr}, {32'b0, e.a});
                chk("imem_data", {32'b0, imemData}, {32'b0, e.d});
            end
        end
        if (imemWe && !prev_we) rises++;
        prev_we = imemWe;
    end

    task automatic fill_rom(input int hlt_pos);
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            w = $urandom;
            if (w[31:26] == HLT) w[31:26] = ~HLT;
            if (i == hlt_pos) w[31:26] = HLT;
            rom[i] = w;
        end
    endtask

    // Reference: copy words in order until the first hlt, error if none exists.
    task automatic build_expect(output int cnt, output bit err);
        exp_q.delete();
        cnt = 0;
        err = 1'b1;
        for (int i = 0; i < 64; i++) begin
            wr_t e;
            e.a = 32'(i);
            e.d = rom[i];
            exp_q.push_back(e);
            cnt++;
            if (rom[i][31:26] == HLT) begin
                err = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_copy(input int hlt_pos, input bit glitch);
        int cnt;
        bit err;
        fill_rom(hlt_pos);
        build_expect(cnt, err);
        rises = 0;
        @(negedge clk_auto) start = 1'b1;
        @(negedge clk_auto) start = 1'b0;
        chk("bios_addr_after_start", {32'b0, biosAddr}, 64'd0);
        chk("busy_after_start", {63'b0, busy}, 64'd1);
        chk("done_cleared", {63'b0, done}, 64'd0);
        chk("error_cleared", {63'b0, error}, 64'd0);
        @(negedge clk_auto);
        chk("we_not_early", {63'b0, imemWe}, 64'd0);
        @(negedge clk_auto);
        chk("first_write_latency", {63'b0, imemWe}, 64'd1);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk_auto);
            start = glitch && imemWe && (imemAddr == 32'd5 || imemAddr == 32'd20);
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 64'd0, 64'd1);
        chk("word_count", {57'b0, wordCount}, 64'(cnt));
        chk("error_flag", {63'b0, error}, {63'b0, err});
        chk("busy_end", {63'b0, busy}, 64'd0);
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
        repeat (5) @(negedge clk_auto);
        chk("write_bursts", 64'(rises), 64'd1);
        chk("done_held", {63'b0, done}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 64; i++) rom[i] = '0;
        repeat (3) @(negedge clk_auto);
        chk("reset_we", {63'b0, imemWe}, 64'd0);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_error", {63'b0, error}, 64'd0);
        chk("reset_count", {57'b0, wordCount}, 64'd0);
        chk("reset_bios_addr", {32'b0, biosAddr}, 64'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_auto);
        chk("idle_no_write", 64'(rises), 64'd0);
        chk("idle_not_busy", {63'b0, busy}, 64'd0);

        run_copy(29, 1'b0);
        run_copy(0, 1'b0);
        run_copy(-1, 1'b0);
        run_copy(29, 1'b0);
        run_copy(63, 1'b0);

        // Mid-copy asynchronous reset while word 10 is on the write port.
        fill_rom(29);
        begin
            int cnt;
            bit err;
            build_expect(cnt, err);
        end
        @(negedge clk_auto) start = 1'b1;
        @(negedge clk_auto) start = 1'b0;
        k = 0;
        while (!(imemWe && imemAddr == 32'd10) && k < 100) begin
            @(negedge clk_auto);
            k++;
        end
        if (k >= 100) chk("word10_timeout", 64'd0, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_we", {63'b0, imemWe}, 64'd0);
        chk("async_reset_busy", {63'b0, busy}, 64'd0);
        chk("async_reset_count", {57'b0, wordCount}, 64'd0);
        chk("async_reset_bios_addr", {32'b0, biosAddr}, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk_auto);
        rst_n = 1'b1;
        run_copy(29, 1'b0);

        run_copy(29, 1'b1);
        for (int r = 0; r < 4; r++) run_copy(int'($urandom_range(0, 63)), r[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bios_loader.md
Name: bios_loader

Overview:
Boot-time reader for the BIOS ROM. After a start pulse it walks BIOS addresses from 0 and captures each registered ROM word. It copies every word into instruction memory through a simple write port, and stops after copying the hlt instruction. It sits between the BIOS ROM's address/biosOut port and the instruction-memory write port, and holds the core off until the copy completes.

Parameters:
BIOS_DEPTH, 64, number of BIOS words; the last readable address is BIOS_DEPTH-1.
DATA_W, 32, instruction width.
ADDR_W, 32, address width on both the BIOS and instruction-memory sides.
IMEM_BASE, 0, instruction-memory address that receives BIOS word 0.
HLT_OPCODE, 6'b011101, opcode in bits [31:26] that ends the copy.

Ports:
clk_auto  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request to begin a copy; honoured only in IDLE or DONE.
biosAddr  out  ADDR_W  address driven to the BIOS ROM.
biosIn  in  DATA_W  BIOS ROM data output; ROM registers bios[biosAddr] on each rising edge.
imemWe  out  1  instruction-memory write enable.
imemAddr  out  ADDR_W  instruction-memory write address.
imemData  out  DATA_W  instruction-memory write data.
busy  out  1  high while a copy is in progress.
done  out  1  high once the copy has finished; held until the next start.
error  out  1  copy ended at BIOS_DEPTH-1 without finding hlt.
wordCount  out  $clog2(BIOS_DEPTH)+1  number of words written in the current or last copy.

Behaviour:
- Clock and reset: one clock (clk_auto). rst_n is asynchronous and active-low.
- Reset: all outputs go to 0 immediately, FSM goes to IDLE, in-flight data is discarded. This also applies mid-copy; imemWe drops without waiting for a clock edge.
- All outputs are registered.
- FSM states:
  - IDLE: start -> LOAD. At that edge: biosAddr<=0, pipeline cleared, wordCount<=0, done<=0, error<=0, busy<=1.
  - LOAD: biosAddr increments by 1 every cycle until issue stops.
  - DRAIN: issue has stopped; remaining valid words finish writing.
  - DONE: busy=0, done=1. start -> LOAD, with the same initialisation as from IDLE.
- Pipeline:
  - A 2-stage valid/address tag tracks each issued address through the ROM's one-cycle register.
  - biosAddr=A is driven after edge e. The ROM latches bios[A] at e+1. At e+2 the loader registers imemWe=1, imemData=biosIn, imemAddr=IMEM_BASE+A and increments wordCount.
  - Latency from address issue to the write is therefore 2 cycles.
  - Throughput is 1 word per clock, so imemWe stays high for consecutive cycles.
- Issue limit: issue stops after address BIOS_DEPTH-1 has been driven; biosAddr holds at BIOS_DEPTH-1.
- hlt detection:
  - Applies when the word being written has biosIn[31:26]==HLT_OPCODE.
  - That word is written.
  - Up to two younger in-flight addresses are squashed and never written.
  - At the next edge: busy<=0, done<=1, imemWe<=0, state=DONE.
- Missing hlt: if the word from BIOS_DEPTH-1 is written and is not hlt, the next edge sets error<=1, done<=1, busy<=0, state=DONE.
- imemWe is low in IDLE and DONE. imemAddr and imemData hold their last values when imemWe=0.
- start while in LOAD or DRAIN is ignored.
- wordCount counts writes including the hlt word; it saturates at BIOS_DEPTH.

Test Plan:
1. Reset: assert rst_n=0 at any time -> every output reads 0 immediately; no imemWe pulse after release without start.
2. Normal program with hlt at BIOS address 29: pulse start ->
   - biosAddr=0 on the cycle after start;
   - first imemWe 2 cycles later;
   - imemWe high for exactly 30 consecutive cycles, imemAddr 0..29, imemData equal to ROM contents;
   - no writes to 30 or 31;
   - afterwards wordCount=30, done=1, error=0, busy=0.
3. hlt at address 0: start -> exactly one write (addr 0), wordCount=1, done=1, error=0.
4. No hlt in any of the 64 words: start -> 64 consecutive writes (addr 0..63), wordCount=64, error=1, done=1.
5. Mid-copy reset: drop rst_n on the cycle word 10 is written ->
   - imemWe falls without waiting for an edge;
   - after release and a new start, a full copy from address 0 completes with wordCount=30.
6. Start handling:
   - start pulses at words 5 and 20 of a copy -> no restart, identical result to scenario 2.
   - start in DONE -> done and error clear on the next edge and a new copy begins at address 0.
